// File: rtl/mod3_residue_tx.sv
// Mod-3 residue link transmitter: serializes a payload LSB-first as dibits and appends a check dibit
// so every transmitted word is 0 mod 3. Optional MOD3_TX_FRAME_COUNT_EN adds a 16-bit frame counter.
module mod3_residue_tx #(
  parameter int PAYLOAD_DIBITS = 31,
  parameter int IDX_W          = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*PAYLOAD_DIBITS-1:0] in_data,
  output logic [1:0]                  out_dibit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [1:0]                  residue,
  output logic                        busy
`ifdef MOD3_TX_FRAME_COUNT_EN
  ,
  output logic [15:0]                 frame_count
`endif
);

  localparam int PW = 2 * PAYLOAD_DIBITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_DIBITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, CHECK} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        residue_q, residue_d;
  logic [1:0]        out_dibit_q, out_dibit_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              beat;
  logic [1:0]        res_next;

  // A raw dibit of 3 is congruent to 0, so one conditional subtract covers the 0..5 range.
  function automatic logic [1:0] mod3_add(input logic [1:0] r, input logic [1:0] d);
    logic [2:0] s;
    s = {1'b0, r} + {1'b0, d};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] check_dibit(input logic [1:0] r);
    case (r)
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  assign beat     = out_valid_q && out_ready;
  assign res_next = mod3_add(residue_q, sreg_q[1:0]);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    residue_d   = residue_q;
    out_dibit_d = out_dibit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sreg_d      = in_data;
          idx_d       = '0;
          residue_d   = 2'd0;
          out_dibit_d = in_data[1:0];
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          residue_d = res_next;
          sreg_d    = sreg_q >> 2;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            out_dibit_d = check_dibit(res_next);
            out_last_d  = 1'b1;
            state_d     = CHECK;
          end else begin
            out_dibit_d = sreg_d[1:0];
          end
        end
      end
      CHECK: begin
        if (beat) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_dibit_d = 2'd0;
          residue_d   = 2'd0;
          idx_d       = '0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      idx_q       <= '0;
      residue_q   <= 2'd0;
      out_dibit_q <= 2'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      idx_q       <= idx_d;
      residue_q   <= residue_d;
      out_dibit_q <= out_dibit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MOD3_TX_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (state_q == CHECK && beat) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_count_q <= 16'd0;
    else     frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_dibit = out_dibit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign residue   = residue_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod3_residue_tx.sv
// Scoreboard bench for mod3_residue_tx: stimulus pushes expected dibits, a monitor pops them on beats.
module tb_mod3_residue_tx;
  localparam int PD = 31;
  localparam int PW = 2 * PD;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic [1:0]    out_dibit;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [1:0]    residue;
  logic          busy;
`ifdef MOD3_TX_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  mod3_residue_tx #(.PAYLOAD_DIBITS(PD), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_dibit(out_dibit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .residue(residue), .busy(busy)
`ifdef MOD3_TX_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];
  bit mon_en = 1'b0;
  bit bp_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (bp_en) begin
      #1 out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each beat against the scoreboard and check stall stability.
  bit         stall_prev = 1'b0;
  logic [1:0] prev_dibit, prev_res;
  logic       prev_last;
  logic [1:0] run_res = 2'd0;
  logic [63:0] word = '0;
  int         word_k = 0;
  int         words_done = 0;
  bit         fc_pending = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0; run_res = 2'd0; word = '0; word_k = 0; words_done = 0; fc_pending = 1'b0;
    end else if (mon_en) begin
`ifdef MOD3_TX_FRAME_COUNT_EN
      if (fc_pending) chk("frame_count", {48'd0, frame_count}, 64'(words_done[15:0]));
`endif
      fc_pending = 1'b0;
      if (stall_prev) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_dibit", {62'd0, out_dibit}, {62'd0, prev_dibit});
        chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
        chk("stall_residue", {62'd0, residue}, {62'd0, prev_res});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {61'd0, out_last, out_dibit}, 64'h7);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("dibit", {62'd0, out_dibit}, {62'd0, e[1:0]});
          chk("last", {63'd0, out_last}, {63'd0, e[2]});
          chk("residue", {62'd0, residue}, {62'd0, run_res});
          word[2*word_k +: 2] = out_dibit;
          word_k++;
          run_res = 2'((run_res + out_dibit) % 3);
          if (e[2]) begin
            chk("word_mod3", word % 64'd3, 64'd0);
            words_done++;
            fc_pending = 1'b1;
            run_res = 2'd0; word = '0; word_k = 0;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_dibit = out_dibit; prev_last = out_last; prev_res = residue;
    end
  end

  function automatic logic [1:0] model_check(input logic [PW-1:0] d);
    int s;
    s = 0;
    for (int k = 0; k < PD; k++) s += int'(d[2*k +: 2]);
    return 2'((3 - (s % 3)) % 3);
  endfunction

  task automatic push_word(input logic [PW-1:0] d, input logic [1:0] c);
    for (int k = 0; k < PD; k++) exp_q.push_back({1'b0, d[2*k +: 2]});
    exp_q.push_back({1'b1, c});
  endtask

  task automatic send(input logic [PW-1:0] d, input logic [1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data = d;
    push_word(d, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = ~d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  logic [PW-1:0] dv[7];
  logic [1:0]    dc[7];
  int            acc_cyc[4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    dv[0] = '0;             dc[0] = 2'd0;
    dv[1] = 62'h1;          dc[1] = 2'd2;
    dv[2] = {PW{1'b1}};     dc[2] = 2'd0;
    dv[3] = 62'h2;          dc[3] = 2'd1;
    dv[4] = 62'h5;          dc[4] = 2'd1;
    dv[5] = 62'hA;          dc[5] = 2'd2;
    dv[6] = 62'h6;          dc[6] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_residue", {62'd0, residue}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_out_dibit", {62'd0, out_dibit}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) send(dv[i], dc[i]);
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [PW-1:0] r;
      r = PW'({$urandom, $urandom});
      send(r, model_check(r));
    end
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // in_valid held high: one accept every PD+2 cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_data = '0;
    for (int a = 0; a < 4; a++) begin
      int n;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
      acc_cyc[a] = cyc;
      push_word('0, 2'd0);
      @(posedge clk);
      #1;
      if (a == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    for (int a = 1; a < 4; a++) chk("accept_spacing", 64'(acc_cyc[a] - acc_cyc[a-1]), 64'(PD + 2));
    drain();

    // Asynchronous reset in the middle of a word
    mon_en = 1'b0;
    send({PW{1'b1}}, 2'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_pre_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_residue", {62'd0, residue}, 64'd0);
    chk("mid_rst_dibit", {62'd0, out_dibit}, 64'd0);
`ifdef MOD3_TX_FRAME_COUNT_EN
    chk("mid_rst_frame_count", {48'd0, frame_count}, 64'd0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    send(62'h1, 2'd2);
    send(62'hA, 2'd2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
